// File: rtl/processor_pkg.sv
// Shared processor definitions: opcode map, halt word, loader state encoding
// and the opcode legality check used by both the loader and the decoder.
package processor_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_OUT   = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [DATA_W-1:0] HALT_WORD = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

    // Opcodes 1100..1110 are unassigned and must never reach the executor.
    function automatic logic opcode_valid(input logic [3:0] op);
        return (op <= OP_OUT) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/program_ram.sv
// Program store: one synchronous write port and two asynchronous read ports
// (executor fetch and operator review). The array is deliberately not reset.
module program_ram
    import processor_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    input  logic [ADDR_W-1:0] review_addr,
    output logic [DATA_W-1:0] review_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign fetch_data  = mem[fetch_addr];
    assign review_data = mem[review_addr];

endmodule

// File: rtl/program_loader.sv
// Operator-driven program loader: validates and stores instruction bytes,
// tracks length and checksum, and serves the stored program to the fetch path.
module program_loader
    import processor_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic [7:0]        data_in,
    input  logic              review,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [7:0]        fetch_instr,
    output logic [7:0]        review_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   prog_len,
    output logic [7:0]        checksum,
    output logic [1:0]        state,
    output logic              full,
    output logic              err,
    output logic              ready
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] rev_ptr;
    logic [ADDR_W:0]   rev_next;
    logic              op_ok, is_halt, last_slot;
    logic              commit, reject, rev_step;
    logic [7:0]        ram_fetch;

    assign op_ok     = opcode_valid(data_in[7:4]);
    assign is_halt   = (data_in[7:4] == OP_HALT);
    assign last_slot = (wr_ptr == ADDR_W'(DEPTH - 1));

    // start always takes priority over a coincident step
    assign commit   = (state_q == ST_LOAD) && step && !start && op_ok;
    assign reject   = (state_q == ST_LOAD) && step && !start && !op_ok;
    assign rev_step = (state_q == ST_DONE) && step && !start && review;
    assign rev_next = {1'b0, rev_ptr} + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else if (commit && (is_halt || last_slot)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state = state_q;
        ready = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            prog_len <= '0;
            checksum <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
            rev_ptr  <= '0;
        end else begin
            err <= reject;
            if (start) begin
                wr_ptr   <= '0;
                prog_len <= '0;
                checksum <= '0;
                full     <= 1'b0;
                rev_ptr  <= '0;
            end else if (commit) begin
                wr_ptr   <= wr_ptr + 1'b1;
                prog_len <= prog_len + 1'b1;
                checksum <= checksum + data_in;
                if (!is_halt && last_slot) begin
                    full <= 1'b1;
                end
            end else if (rev_step) begin
                rev_ptr <= (rev_next == prog_len) ? '0 : rev_next[ADDR_W-1:0];
            end
        end
    end

    program_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk         (clk),
        .wr_en       (commit),
        .wr_addr     (wr_ptr),
        .wr_data     (data_in),
        .fetch_addr  (fetch_addr),
        .fetch_data  (ram_fetch),
        .review_addr (rev_ptr),
        .review_data (review_data)
    );

    // Stale words beyond the current length read back as HALT.
    assign fetch_instr = ({1'b0, fetch_addr} < prog_len) ? ram_fetch : HALT_WORD;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: committed words and review reads are
// queued as stimulus is driven and compared as the DUT presents them.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset, start, step, review;
    logic [7:0] data_in;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_instr, review_data, checksum;
    logic [3:0] wr_ptr;
    logic [4:0] prog_len;
    logic [1:0] state;
    logic       full, err, ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] rev_q[$];
    logic [3:0] model_wr;

    program_loader #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step        (step),
        .data_in     (data_in),
        .review      (review),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .review_data (review_data),
        .wr_ptr      (wr_ptr),
        .prog_len    (prog_len),
        .checksum    (checksum),
        .state       (state),
        .full        (full),
        .err         (err),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_wr = 4'd0;
        sb_q.delete();
    endtask

    // Commits d; the bench's own opcode map decides whether a word is expected.
    task automatic load_word(input logic [7:0] d);
        if (d[7:4] <= 4'hB || d[7:4] == 4'hF) begin
            sb_q.push_back('{addr: model_wr, data: d});
            model_wr = model_wr + 4'd1;
        end
        data_in = d;
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic drain_fetch(input string tag, input int exp_count);
        sb_t e;
        int  n = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            fetch_addr = e.addr;
            #1;
            check_eq(tag, 32'(fetch_instr), 32'(e.data));
            n++;
        end
        check_eq({tag, "_count"}, n, exp_count);
    endtask

    task automatic check_all_halt(input string tag);
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a);
            #1;
            check_eq(tag, 32'(fetch_instr), 32'hF0);
        end
    endtask

    initial begin
        logic [7:0] basic [4];
        basic[0] = 8'h90; basic[1] = 8'hA4; basic[2] = 8'h01; basic[3] = 8'hF0;
        reset = 1'b1; start = 1'b0; step = 1'b0; review = 1'b0;
        data_in = 8'h00; fetch_addr = 4'd0; model_wr = 4'd0;
        tick(); tick();
        reset = 1'b0;

        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_len", 32'(prog_len), 32'd0);
        check_eq("rst_sum", 32'(checksum), 32'd0);
        check_eq("rst_wr", 32'(wr_ptr), 32'd0);
        check_eq("rst_flags", {29'd0, full, err, ready}, 32'd0);
        check_all_halt("rst_fetch");

        // step is ignored in IDLE
        data_in = 8'h11; step = 1'b1; tick(); step = 1'b0;
        check_eq("idle_step_len", 32'(prog_len), 32'd0);
        check_eq("idle_step_state", 32'(state), 32'd0);

        // Basic load
        do_start();
        check_eq("start_state", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) load_word(basic[i]);
        check_eq("basic_state", 32'(state), 32'd2);
        check_eq("basic_ready", 32'(ready), 32'd1);
        check_eq("basic_len", 32'(prog_len), 32'd4);
        check_eq("basic_sum", 32'(checksum), 32'h25);
        check_eq("basic_full", 32'(full), 32'd0);
        drain_fetch("basic_fetch", 4);
        fetch_addr = 4'd5; #1;
        check_eq("basic_fetch5", 32'(fetch_instr), 32'hF0);

        // Review walk with wrap at prog_len
        check_eq("review_init", 32'(review_data), 32'h90);
        data_in = 8'h00; step = 1'b1; tick(); step = 1'b0;
        check_eq("review_off", 32'(review_data), 32'h90);
        review = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rev_q.push_back(basic[(i + 1) % 4]);
            step = 1'b1; tick(); step = 1'b0;
            check_eq("review_seq", 32'(review_data), 32'(rev_q.pop_front()));
        end
        review = 1'b0;
        check_eq("review_len", 32'(prog_len), 32'd4);

        // Invalid opcodes are rejected with a one-cycle err pulse
        do_start();
        check_eq("restart_len", 32'(prog_len), 32'd0);
        load_word(8'h12);
        check_eq("valid_err", 32'(err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] bad;
            bad = {4'hC + 4'(k), 4'h3};
            load_word(bad);
            check_eq("inv_err", 32'(err), 32'd1);
            check_eq("inv_wr", 32'(wr_ptr), 32'd1);
            check_eq("inv_len", 32'(prog_len), 32'd1);
            check_eq("inv_sum", 32'(checksum), 32'h12);
            check_eq("inv_state", 32'(state), 32'd1);
            tick();
            check_eq("inv_err_clear", 32'(err), 32'd0);
        end
        load_word(8'hB5);
        load_word(8'h33);
        check_eq("pre_clash_len", 32'(prog_len), 32'd3);
        drain_fetch("inv_fetch", 3);

        // start and step together: start wins
        data_in = 8'h20; start = 1'b1; step = 1'b1; tick();
        start = 1'b0; step = 1'b0;
        model_wr = 4'd0;
        check_eq("clash_len", 32'(prog_len), 32'd0);
        check_eq("clash_sum", 32'(checksum), 32'd0);
        check_eq("clash_wr", 32'(wr_ptr), 32'd0);
        check_eq("clash_state", 32'(state), 32'd1);
        fetch_addr = 4'd0; #1;
        check_eq("clash_fetch0", 32'(fetch_instr), 32'hF0);

        // Fill all 16 slots without HALT
        for (int i = 0; i < 15; i++) load_word(8'h01);
        check_eq("pre_full_state", 32'(state), 32'd1);
        check_eq("pre_full_flag", 32'(full), 32'd0);
        load_word(8'h01);
        check_eq("full_flag", 32'(full), 32'd1);
        check_eq("full_state", 32'(state), 32'd2);
        check_eq("full_len", 32'(prog_len), 32'd16);
        check_eq("full_wr", 32'(wr_ptr), 32'd0);
        check_eq("full_sum", 32'(checksum), 32'h10);
        drain_fetch("full_fetch", 16);

        // Reset in the middle of a load
        do_start();
        check_eq("reload_full", 32'(full), 32'd0);
        load_word(8'h55);
        load_word(8'h66);
        check_eq("mid_len", 32'(prog_len), 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        sb_q.delete();
        check_eq("mrst_state", 32'(state), 32'd0);
        check_eq("mrst_len", 32'(prog_len), 32'd0);
        check_eq("mrst_ready", 32'(ready), 32'd0);
        check_all_halt("mrst_fetch");
        load_word(8'h77);
        sb_q.delete();
        check_eq("mrst_step_len", 32'(prog_len), 32'd0);
        check_eq("mrst_step_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
